sram_like_responder: RTL and testbench

//  Slave end of the SRAM-like req/addr_ok/data_ok bus that the CPU core drives on its inst/data ports.
//  It accepts requests, keeps up to OUTSTANDING of them in an in-order queue, and returns data_ok/rdata
//  a fixed LATENCY after acceptance. It is backed by a word-addressed RAM.

---
 rtl/sram_like_responder.sv | 106 ++++++++++
 tb/tb_sram_like_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_responder.sv
// Slave end of the SRAM-like req/addr_ok/data_ok bus. Accepted requests enter
// an in-order queue of up to OUTSTANDING entries and are answered with a
// one-cycle data_ok pulse exactly LATENCY cycles after acceptance. The backing
// store is a word-addressed RAM. Writes commit, and reads sample, at the
// accept edge, so every read observes exactly the writes accepted before it.
module sram_like_responder #(
  parameter int    ADDR_WIDTH  = 16,
  parameter int    OUTSTANDING = 4,
  parameter int    LATENCY     = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int AGE_W = $clog2(LATENCY + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
  localparam logic [AGE_W-1:0] AGE_DUE  = AGE_W'(LATENCY);
  // The accept edge itself counts as the first elapsed cycle, so a request
  // accepted at edge k is answered in the cycle after edge k+LATENCY-1.
  localparam logic [AGE_W-1:0] AGE_NEW  = AGE_W'(1);

  logic [31:0]           mem    [DEPTH];
  logic                  q_wr   [OUTSTANDING];
  logic [31:0]           q_data [OUTSTANDING];
  logic [AGE_W-1:0]      q_age  [OUTSTANDING];

  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  accept;
  logic                  pop;

  // size, the byte offset and the address bits above the RAM index have no
  // effect: every access is a full word and the index simply wraps.
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0]};

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign idx     = addr[ADDR_WIDTH+1:2];
  // Registered state only: a full queue refuses even when it pops this cycle.
  assign addr_ok = (count != CNT_FULL);
  assign accept  = req && addr_ok;
  assign data_ok = (count != '0) && (q_age[head] == AGE_DUE);
  assign pop     = data_ok;
  assign rdata   = (data_ok && !q_wr[head]) ? q_data[head] : 32'h0;

  // RAM access and queue payload capture at the accept edge.
  // NOTE: RAM and payload slots carry no reset; a slot is only ever read
  // after an accept has filled it, so validity lives in count/head/tail.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_wr[tail]   <= wr;
      q_data[tail] <= mem[idx];
      if (wr) begin
        for (int i = 0; i < 4; i++) begin
          if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Queue control: pointers, occupancy and per-slot saturating ages.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < OUTSTANDING; i++) q_age[i] <= '0;
    end else begin
      // Stale slots age harmlessly; they are re-seeded when refilled.
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (q_age[i] != AGE_DUE) q_age[i] <= q_age[i] + 1'b1;
      end
      if (accept) begin
        q_age[tail] <= AGE_NEW;
        tail        <= next_ptr(tail);
      end
      if (pop) head <= next_ptr(head);
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Self-checking bench for sram_like_responder. Two instances: a main one
// (ADDR_WIDTH=16, OUTSTANDING=4, LATENCY=2) and a small one (ADDR_WIDTH=4,
// OUTSTANDING=4, LATENCY=8) for address wrap and queue-full behaviour.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sram_like_responder;

  localparam int M_AW = 16, M_OUT = 4, M_LAT = 2;
  localparam int S_AW = 4,  S_OUT = 4, S_LAT = 8;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic        s_req, s_wr, s_addr_ok, s_data_ok;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata, s_rdata;

  sram_like_responder #(.ADDR_WIDTH(M_AW), .OUTSTANDING(M_OUT), .LATENCY(M_LAT)) u_main (
    .clk(clk), .resetn(resetn), .req(m_req), .wr(m_wr), .size(m_size), .wstrb(m_wstrb),
    .addr(m_addr), .wdata(m_wdata), .addr_ok(m_addr_ok), .data_ok(m_data_ok), .rdata(m_rdata)
  );

  sram_like_responder #(.ADDR_WIDTH(S_AW), .OUTSTANDING(S_OUT), .LATENCY(S_LAT)) u_small (
    .clk(clk), .resetn(resetn), .req(s_req), .wr(s_wr), .size(s_size), .wstrb(s_wstrb),
    .addr(s_addr), .wdata(s_wdata), .addr_ok(s_addr_ok), .data_ok(s_data_ok), .rdata(s_rdata)
  );

  typedef struct {
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_aok;
    logic        exp_dok;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic m_drive(input logic req, input logic wr, input logic [3:0] wstrb,
                         input logic [31:0] addr, input logic [31:0] wdata);
    m_req = req; m_wr = wr; m_wstrb = wstrb; m_addr = addr; m_wdata = wdata; m_size = 2'd2;
  endtask

  task automatic s_drive(input logic req, input logic wr, input logic [3:0] wstrb,
                         input logic [31:0] addr, input logic [31:0] wdata);
    s_req = req; s_wr = wr; s_wstrb = wstrb; s_addr = addr; s_wdata = wdata; s_size = 2'd0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic req, input logic wr, input logic [3:0] wstrb,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic dok, input logic [31:0] rd);
    vec_t v;
    v.req = req; v.wr = wr; v.wstrb = wstrb; v.addr = addr; v.wdata = wdata;
    v.exp_aok = 1'b1; v.exp_dok = dok; v.exp_rdata = rd;
    return v;
  endfunction

  function automatic logic [31:0] stream_word(input int i);
    return {8'hA5, 8'(i), 16'(i * 37 + 5)};
  endfunction

  vec_t        vecs [21];
  exp_t        q [$];
  logic [31:0] mm [16];

  initial begin
    // Per-cycle vectors for the main instance (response two rows after request).
    vecs[0]  = mk(1, 1, 4'hF, 32'h10,       32'hDEADBEEF, 0, 32'h0);
    vecs[1]  = mk(1, 1, 4'hF, 32'h20,       32'h0,        0, 32'h0);
    vecs[2]  = mk(0, 0, 4'h0, 32'h0,        32'h0,        1, 32'h0);
    vecs[3]  = mk(1, 0, 4'h0, 32'h10,       32'h0,        1, 32'h0);
    vecs[4]  = mk(0, 0, 4'h0, 32'h0,        32'h0,        0, 32'h0);
    vecs[5]  = mk(0, 0, 4'h0, 32'h0,        32'h0,        1, 32'hDEADBEEF);
    vecs[6]  = mk(1, 1, 4'h5, 32'h20,       32'h11223344, 0, 32'h0);
    vecs[7]  = mk(1, 0, 4'h0, 32'h20,       32'h0,        0, 32'h0);
    vecs[8]  = mk(0, 0, 4'h0, 32'h0,        32'h0,        1, 32'h0);
    vecs[9]  = mk(0, 0, 4'h0, 32'h0,        32'h0,        1, 32'h00220044);
    vecs[10] = mk(1, 1, 4'h0, 32'h10,       32'hFFFFFFFF, 0, 32'h0);
    vecs[11] = mk(1, 0, 4'h0, 32'h10,       32'h0,        0, 32'h0);
    vecs[12] = mk(0, 0, 4'h0, 32'h0,        32'h0,        1, 32'h0);
    vecs[13] = mk(1, 0, 4'h0, 32'h12,       32'h0,        1, 32'hDEADBEEF);
    vecs[14] = mk(0, 0, 4'h0, 32'h0,        32'h0,        0, 32'h0);
    vecs[15] = mk(0, 0, 4'h0, 32'h0,        32'h0,        1, 32'hDEADBEEF);
    vecs[16] = mk(1, 1, 4'h8, 32'h10,       32'hAABBCCDD, 0, 32'h0);
    vecs[17] = mk(1, 0, 4'h0, 32'h00040010, 32'h0,        0, 32'h0);
    vecs[18] = mk(0, 0, 4'h0, 32'h0,        32'h0,        1, 32'h0);
    vecs[19] = mk(0, 0, 4'h0, 32'h0,        32'h0,        1, 32'hAAADBEEF);
    vecs[20] = mk(0, 0, 4'h0, 32'h0,        32'h0,        0, 32'h0);

    resetn = 1'b0;
    m_drive(0, 0, 4'h0, 32'h0, 32'h0);
    s_drive(0, 0, 4'h0, 32'h0, 32'h0);
    repeat (2) tick();
    check("reset_m_dok",   m_data_ok, 0);
    check("reset_m_rdata", m_rdata,   0);
    check("reset_s_dok",   s_data_ok, 0);
    resetn = 1'b1;
    tick();
    check("release_m_aok", m_addr_ok, 1);
    check("release_s_aok", s_addr_ok, 1);

    // Single read, write-then-read, wstrb=0, ignored address bits.
    for (int r = 0; r < 21; r++) begin
      check($sformatf("vec%0d_aok", r),   m_addr_ok, vecs[r].exp_aok);
      check($sformatf("vec%0d_dok", r),   m_data_ok, vecs[r].exp_dok);
      check($sformatf("vec%0d_rdata", r), m_rdata,   vecs[r].exp_rdata);
      m_drive(vecs[r].req, vecs[r].wr, vecs[r].wstrb, vecs[r].addr, vecs[r].wdata);
      tick();
    end
    m_drive(0, 0, 4'h0, 32'h0, 32'h0);

    // Index wrap on the small instance: 0x40 lands in word 0.
    s_drive(1, 1, 4'hF, 32'h40, 32'hCAFEF00D);
    tick();
    s_drive(1, 0, 4'h0, 32'h0, 32'h0);
    tick();
    s_drive(0, 0, 4'h0, 32'h0, 32'h0);
    for (int c = 2; c <= 10; c++) begin
      check($sformatf("wrap_c%0d_dok", c),   s_data_ok, (c == 8 || c == 9));
      check($sformatf("wrap_c%0d_rdata", c), s_rdata,   (c == 9) ? 32'hCAFEF00D : 32'h0);
      tick();
    end

    // Full queue: req held high through cycle 17, LATENCY=8.
    for (int c = 0; c <= 24; c++) begin
      logic exp_aok, exp_dok;
      exp_aok = (c <= 3) || (c >= 9 && c <= 12) || (c >= 18);
      exp_dok = (c >= 8 && c <= 11) || (c >= 17 && c <= 20);
      check($sformatf("full_c%0d_aok", c),   s_addr_ok, exp_aok);
      check($sformatf("full_c%0d_dok", c),   s_data_ok, exp_dok);
      check($sformatf("full_c%0d_rdata", c), s_rdata,   exp_dok ? 32'hCAFEF00D : 32'h0);
      s_drive(c <= 17, 0, 4'h0, 32'h0, 32'h0);
      tick();
    end
    s_drive(0, 0, 4'h0, 32'h0, 32'h0);

    // Reset mid-stream with pending responses on both instances.
    for (int c = 0; c < 3; c++) begin
      m_drive(1, 0, 4'h0, 32'h10, 32'h0);
      s_drive(1, 0, 4'h0, 32'h0,  32'h0);
      tick();
    end
    m_drive(0, 0, 4'h0, 32'h0, 32'h0);
    s_drive(0, 0, 4'h0, 32'h0, 32'h0);
    check("rst_pre_m_dok", m_data_ok, 1);
    resetn = 1'b0;
    #1;
    check("rst_m_dok",   m_data_ok, 0);
    check("rst_m_rdata", m_rdata,   0);
    check("rst_s_dok",   s_data_ok, 0);
    check("rst_s_rdata", s_rdata,   0);
    tick();
    resetn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      check($sformatf("post_rst_c%0d_m_aok", c), m_addr_ok, 1);
      check($sformatf("post_rst_c%0d_m_dok", c), m_data_ok, 0);
      check($sformatf("post_rst_c%0d_s_aok", c), s_addr_ok, 1);
      check($sformatf("post_rst_c%0d_s_dok", c), s_data_ok, 0);
      tick();
    end

    // RAM survives reset.
    m_drive(1, 0, 4'h0, 32'h10, 32'h0);
    tick();
    m_drive(0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    check("ram_kept_dok",   m_data_ok, 1);
    check("ram_kept_rdata", m_rdata,   32'hAAADBEEF);
    tick();

    // Streaming: preload 16 words, then 16 back-to-back reads.
    for (int i = 0; i < 16; i++) begin
      m_drive(1, 1, 4'hF, 32'h100 + 32'(4 * i), stream_word(i));
      mm[i] = stream_word(i);
      tick();
    end
    m_drive(0, 0, 4'h0, 32'h0, 32'h0);
    repeat (3) tick();
    for (int c = 0; c < 20; c++) begin
      logic exp_dok;
      exp_dok = (c >= 2 && c <= 17);
      check($sformatf("stream_c%0d_aok", c),   m_addr_ok, 1);
      check($sformatf("stream_c%0d_dok", c),   m_data_ok, exp_dok);
      check($sformatf("stream_c%0d_rdata", c), m_rdata,   exp_dok ? stream_word(c - 2) : 32'h0);
      m_drive(c < 16, 0, 4'h0, 32'h100 + 32'(4 * c), 32'h0);
      tick();
    end
    m_drive(0, 0, 4'h0, 32'h0, 32'h0);
    tick();

    // Random traffic against a due-time queue model over the 16 preloaded words.
    for (int c = 0; c < 400; c++) begin
      logic        exp_aok, exp_dok, req, wr;
      logic [3:0]  wstrb;
      logic [31:0] addr, wdata, exp_rd;
      int          k;
      exp_aok = (q.size() != M_OUT);
      exp_dok = (q.size() > 0) && (q[0].due <= c);
      exp_rd  = exp_dok ? q[0].data : 32'h0;
      check($sformatf("rand_c%0d_aok", c),   m_addr_ok, exp_aok);
      check($sformatf("rand_c%0d_dok", c),   m_data_ok, exp_dok);
      check($sformatf("rand_c%0d_rdata", c), m_rdata,   exp_rd);
      if (exp_dok) void'(q.pop_front());
      req   = ($urandom_range(0, 99) < 70);
      wr    = ($urandom_range(0, 2) == 0);
      k     = int'($urandom_range(0, 15));
      wstrb = 4'($urandom);
      wdata = $urandom;
      addr  = {14'($urandom), 16'(16'h0040 + 16'(k)), 2'($urandom)};
      m_drive(req, wr, wstrb, addr, wdata);
      if (req && exp_aok) begin
        exp_t e;
        e.due  = c + M_LAT;
        e.data = wr ? 32'h0 : mm[k];
        q.push_back(e);
        if (wr) begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mm[k][8*b +: 8] = wdata[8*b +: 8];
          end
        end
      end
      tick();
    end
    m_drive(0, 0, 4'h0, 32'h0, 32'h0);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
